race_phase_sequencer: RTL and testbench

//  Top-level game-phase FSM for the race: idle, start countdown, race, crash recovery, finish, game over.

---
 rtl/race_phase_sequencer.sv | 152 +++++++++++++++
 tb/tb_race_phase_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/race_phase_sequencer.sv
// Race game-phase FSM: countdown, race, crash recovery, finish and game over.
// Latency: every output is registered; a phase change appears the cycle after its trigger edge.
// No handshake: single-cycle pulse inputs are consumed in the cycle they arrive, never stalled.
module race_phase_sequencer #(
  parameter int COUNTDOWN_SEC = 3,
  parameter int CRASH_SEC     = 2,
  parameter int FUEL_INIT     = 99,
  parameter int CRASH_PENALTY = 5,
  parameter int FINISH_DIST   = 1000,
  parameter int DIST_W        = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_req,
  input  logic              one_sec,
  input  logic              start_of_frame,
  input  logic [1:0]        speed,
  input  logic              collision,
  output logic [2:0]        phase,
  output logic              brake,
  output logic [1:0]        countdown,
  output logic [6:0]        fuel,
  output logic [DIST_W-1:0] distance,
  output logic              crash_blink,
  output logic              win,
  output logic              game_over
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RACE      = 3'd2,
    S_CRASH     = 3'd3,
    S_FINISH    = 3'd4,
    S_OVER      = 3'd5
  } state_t;

  localparam logic [1:0]        CD_LOAD    = COUNTDOWN_SEC[1:0];
  localparam logic [1:0]        CRASH_LOAD = CRASH_SEC[1:0];
  localparam logic [6:0]        FUEL_LOAD  = FUEL_INIT[6:0];
  localparam logic [6:0]        PENALTY    = CRASH_PENALTY[6:0];
  localparam logic [DIST_W-1:0] DIST_MAX   = FINISH_DIST[DIST_W-1:0];

  state_t            state, state_n;
  logic [1:0]        countdown_n;
  logic [6:0]        fuel_n;
  logic [DIST_W-1:0] distance_n;
  logic [2:0]        frame_cnt, frame_cnt_n;

  logic [1:0]        speed_eff;
  logic [DIST_W:0]   dist_sum;
  logic [DIST_W-1:0] dist_acc;
  logic [6:0]        fuel_acc;
  logic [6:0]        fuel_after;
  logic [6:0]        fuel_crash;

  assign phase = state;

  // Saturating arithmetic for distance gain, fuel burn and the crash penalty.
  always_comb begin
    speed_eff  = (speed == 2'd3) ? 2'd2 : speed;
    dist_sum   = {1'b0, distance} + {{(DIST_W-1){1'b0}}, speed_eff};
    dist_acc   = (dist_sum >= {1'b0, DIST_MAX}) ? DIST_MAX : dist_sum[DIST_W-1:0];
    fuel_acc   = (fuel > {5'd0, speed_eff}) ? (fuel - {5'd0, speed_eff}) : 7'd0;
    fuel_after = one_sec ? fuel_acc : fuel;
    fuel_crash = (fuel_after > PENALTY) ? (fuel_after - PENALTY) : 7'd0;
  end

  // Next-state and next-counter logic; exits from RACE look at the registered values.
  always_comb begin
    state_n     = state;
    countdown_n = countdown;
    fuel_n      = fuel;
    distance_n  = distance;
    frame_cnt_n = frame_cnt;
    case (state)
      S_IDLE, S_FINISH: begin
        if (start_req) begin
          state_n     = S_COUNTDOWN;
          countdown_n = CD_LOAD;
          fuel_n      = FUEL_LOAD;
          distance_n  = '0;
        end
      end
      S_COUNTDOWN: begin
        if (one_sec) begin
          if (countdown == 2'd1) begin
            state_n     = S_RACE;
            countdown_n = 2'd0;
          end else begin
            countdown_n = countdown - 2'd1;
          end
        end
      end
      S_RACE: begin
        if (start_of_frame) distance_n = dist_acc;
        if (one_sec)        fuel_n     = fuel_acc;
        if (distance == DIST_MAX) begin
          state_n = S_FINISH;
        end else if (fuel == 7'd0) begin
          state_n = S_OVER;
        end else if (collision) begin
          state_n     = S_CRASH;
          countdown_n = CRASH_LOAD;
          fuel_n      = fuel_crash;
          frame_cnt_n = 3'd0;
        end
      end
      S_CRASH: begin
        if (start_of_frame) frame_cnt_n = frame_cnt + 3'd1;
        if (one_sec) begin
          if (countdown == 2'd1) begin
            countdown_n = 2'd0;
            state_n     = (fuel == 7'd0) ? S_OVER : S_RACE;
          end else begin
            countdown_n = countdown - 2'd1;
          end
        end
      end
      S_OVER: begin
        if (start_req) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters and decoded HUD outputs all update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      countdown   <= CD_LOAD;
      fuel        <= FUEL_LOAD;
      distance    <= '0;
      frame_cnt   <= 3'd0;
      brake       <= 1'b0;
      crash_blink <= 1'b0;
      win         <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      countdown   <= countdown_n;
      fuel        <= fuel_n;
      distance    <= distance_n;
      frame_cnt   <= frame_cnt_n;
      brake       <= (state_n == S_RACE);
      crash_blink <= (state_n == S_CRASH) && frame_cnt_n[2];
      win         <= (state_n == S_FINISH);
      game_over   <= (state_n == S_OVER);
    end
  end

endmodule

// File: tb/tb_race_phase_sequencer.sv
// Bench for race_phase_sequencer: directed stimulus with hand-computed expectations.
// Expected values are queued per cycle; a negedge monitor pops and compares them.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_race_phase_sequencer;

  localparam int F_PHASE = 0;
  localparam int F_BRAKE = 1;
  localparam int F_CD    = 2;
  localparam int F_FUEL  = 3;
  localparam int F_DIST  = 4;
  localparam int F_BLINK = 5;
  localparam int F_WIN   = 6;
  localparam int F_GO    = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_req = 1'b0;
  logic       one_sec = 1'b0;
  logic       start_of_frame = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       collision = 1'b0;
  logic [2:0] phase;
  logic       brake;
  logic [1:0] countdown;
  logic [6:0] fuel;
  logic [9:0] distance;
  logic       crash_blink;
  logic       win;
  logic       game_over;

  race_phase_sequencer dut (
    .clk(clk), .reset(reset), .start_req(start_req), .one_sec(one_sec),
    .start_of_frame(start_of_frame), .speed(speed), .collision(collision),
    .phase(phase), .brake(brake), .countdown(countdown), .fuel(fuel),
    .distance(distance), .crash_blink(crash_blink), .win(win), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  string sb_name[$];
  int    sb_field[$];
  int    sb_val[$];
  int    sb_tag[$];
  int    checks = 0;
  int    errors = 0;
  logic  done = 1'b0;

  function automatic int actual(input int f);
    case (f)
      F_PHASE: return int'(phase);
      F_BRAKE: return int'(brake);
      F_CD:    return int'(countdown);
      F_FUEL:  return int'(fuel);
      F_DIST:  return int'(distance);
      F_BLINK: return int'(crash_blink);
      F_WIN:   return int'(win);
      F_GO:    return int'(game_over);
      default: return -1;
    endcase
  endfunction

  // Queue an expectation for the outputs visible after the edge just taken.
  task automatic exp_out(input string n, input int f, input int v);
    sb_name.push_back(n);
    sb_field.push_back(f);
    sb_val.push_back(v);
    sb_tag.push_back(cyc);
  endtask

  task automatic step(input logic sr, input logic os, input logic sof, input logic col);
    start_req      = sr;
    one_sec        = os;
    start_of_frame = sof;
    collision      = col;
    @(posedge clk);
    #1;
    start_req      = 1'b0;
    one_sec        = 1'b0;
    start_of_frame = 1'b0;
    collision      = 1'b0;
  endtask

  task automatic step_n(input int n, input logic os, input logic sof);
    for (int i = 0; i < n; i++) step(1'b0, os, sof, 1'b0);
  endtask

  // Monitor: compare every expectation due this cycle; leftovers at the end are errors.
  always begin : monitor
    string n;
    int    f;
    int    v;
    int    a;
    @(negedge clk);
    while (sb_tag.size() > 0 && (sb_tag[0] <= cyc || done)) begin
      n = sb_name.pop_front();
      f = sb_field.pop_front();
      v = sb_val.pop_front();
      void'(sb_tag.pop_front());
      checks++;
      if (done) begin
        errors++;
        $display("FAIL %s: never sampled, expected %0d", n, v);
      end else begin
        a = actual(f);
        if (a != v) begin
          errors++;
          $display("FAIL %s: got %0d, expected %0d", n, a, v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    exp_out("rst_phase", F_PHASE, 0);
    exp_out("rst_brake", F_BRAKE, 0);
    exp_out("rst_cd", F_CD, 3);
    exp_out("rst_fuel", F_FUEL, 99);
    exp_out("rst_dist", F_DIST, 0);
    exp_out("rst_blink", F_BLINK, 0);
    exp_out("rst_win", F_WIN, 0);
    exp_out("rst_go", F_GO, 0);

    // IDLE ignores one_sec
    step(1'b0, 1'b1, 1'b0, 1'b0);
    exp_out("idle_os_phase", F_PHASE, 0);
    exp_out("idle_os_cd", F_CD, 3);

    // Countdown 3,2,1,0 then RACE
    speed = 2'd2;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_out("cd_start_phase", F_PHASE, 1);
    exp_out("cd_start_cd", F_CD, 3);
    exp_out("cd_start_brake", F_BRAKE, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    exp_out("cd_2", F_CD, 2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    exp_out("cd_col_ignored_phase", F_PHASE, 1);
    exp_out("cd_col_ignored_cd", F_CD, 2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    exp_out("cd_1", F_CD, 1);
    exp_out("cd_1_phase", F_PHASE, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    exp_out("cd_0", F_CD, 0);
    exp_out("race_phase", F_PHASE, 2);
    exp_out("race_brake", F_BRAKE, 1);
    exp_out("race_fuel", F_FUEL, 99);

    // Distance and fuel accumulation
    step(1'b0, 1'b0, 1'b1, 1'b0);
    exp_out("dist_first", F_DIST, 2);
    step_n(9, 1'b0, 1'b1);
    exp_out("dist_20", F_DIST, 20);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    exp_out("fuel_97", F_FUEL, 97);
    speed = 2'd1;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    exp_out("both_dist", F_DIST, 21);
    exp_out("both_fuel", F_FUEL, 96);
    speed = 2'd3;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    exp_out("speed3_dist", F_DIST, 23);

    // Crash with fuel 10
    speed = 2'd2;
    step_n(43, 1'b1, 1'b0);
    exp_out("pre_crash_fuel", F_FUEL, 10);
    exp_out("pre_crash_phase", F_PHASE, 2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    exp_out("crash_phase", F_PHASE, 3);
    exp_out("crash_fuel", F_FUEL, 5);
    exp_out("crash_brake", F_BRAKE, 0);
    exp_out("crash_cd", F_CD, 2);
    exp_out("crash_blink0", F_BLINK, 0);
    speed = 2'd3;
    step_n(3, 1'b0, 1'b1);
    exp_out("blink_f3", F_BLINK, 0);
    exp_out("crash_dist_frozen", F_DIST, 23);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    exp_out("blink_f4", F_BLINK, 1);
    step_n(3, 1'b0, 1'b1);
    exp_out("blink_f7", F_BLINK, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    exp_out("blink_f8", F_BLINK, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    exp_out("crash_col_phase", F_PHASE, 3);
    exp_out("crash_col_fuel", F_FUEL, 5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    exp_out("crash_cd1", F_CD, 1);
    exp_out("crash_cd1_phase", F_PHASE, 3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    exp_out("recover_phase", F_PHASE, 2);
    exp_out("recover_cd", F_CD, 0);
    exp_out("recover_brake", F_BRAKE, 1);
    exp_out("recover_fuel", F_FUEL, 5);

    // Distance saturation and finish priority over collision
    speed = 2'd2;
    step_n(488, 1'b0, 1'b1);
    exp_out("dist_999", F_DIST, 999);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    exp_out("dist_sat", F_DIST, 1000);
    exp_out("dist_sat_phase", F_PHASE, 2);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    exp_out("finish_phase", F_PHASE, 4);
    exp_out("finish_win", F_WIN, 1);
    exp_out("finish_brake", F_BRAKE, 0);
    exp_out("finish_dist", F_DIST, 1000);
    exp_out("finish_fuel", F_FUEL, 5);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_out("restart_phase", F_PHASE, 1);
    exp_out("restart_cd", F_CD, 3);
    exp_out("restart_fuel", F_FUEL, 99);
    exp_out("restart_dist", F_DIST, 0);
    exp_out("restart_win", F_WIN, 0);

    // Fuel exhaustion -> OVER -> IDLE
    step_n(3, 1'b1, 1'b0);
    exp_out("race2_phase", F_PHASE, 2);
    step_n(49, 1'b1, 1'b0);
    exp_out("fuel_1", F_FUEL, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    exp_out("fuel_0", F_FUEL, 0);
    exp_out("fuel_0_phase", F_PHASE, 2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_out("over_phase", F_PHASE, 5);
    exp_out("over_go", F_GO, 1);
    exp_out("over_brake", F_BRAKE, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_out("over_idle_phase", F_PHASE, 0);
    exp_out("over_idle_go", F_GO, 0);

    // Crash penalty saturation, then reset mid-CRASH
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_out("race3_cd_phase", F_PHASE, 1);
    exp_out("race3_fuel", F_FUEL, 99);
    step_n(3, 1'b1, 1'b0);
    step_n(48, 1'b1, 1'b0);
    exp_out("fuel_3", F_FUEL, 3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    exp_out("race3_dist", F_DIST, 2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    exp_out("pen_sat_fuel", F_FUEL, 0);
    exp_out("pen_sat_phase", F_PHASE, 3);
    step_n(4, 1'b0, 1'b1);
    exp_out("pre_rst_blink", F_BLINK, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    exp_out("pre_rst_cd", F_CD, 1);
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    exp_out("mid_rst_phase", F_PHASE, 0);
    exp_out("mid_rst_fuel", F_FUEL, 99);
    exp_out("mid_rst_dist", F_DIST, 0);
    exp_out("mid_rst_brake", F_BRAKE, 0);
    exp_out("mid_rst_blink", F_BLINK, 0);
    exp_out("mid_rst_cd", F_CD, 3);

    step_n(2, 1'b0, 1'b0);
    done = 1'b1;
    step_n(2, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
